bw_bbox_detector: RTL and testbench
===================================

Name: bw_bbox_detector

Overview:
- Sits directly downstream of the grayscale/threshold stage.
- Consumes its raster-order pixel stream (valid, bw, color) for one 800x600 frame.
- Rejects horizontal noise shorter than RUN_MIN pixels, then reports the bounding box and count of qualifying dark pixels.
- Results feed the overlay/tracking logic and are held stable until the next frame completes.

Parameters:
- IMG_W, 800, pixels per row; x counter wraps at IMG_W-1.
- IMG_H, 600, rows per frame; last pixel is (IMG_W-1, IMG_H-1).
- RUN_MIN, 3, minimum consecutive dark pixels in one row for them to qualify (1..15).
- MIN_COUNT, 64, qualifying-pixel count at or above which o_found is set.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  arms capture of the next frame; pulse, sampled in S_IDLE only
- i_valid  in  1  pixel beat valid from upstream
- i_bw  in  1  1 = dark/foreground pixel
- i_color  in  10  luma; carried for debug only, not used in decisions
- o_busy  out  1  high in S_ACTIVE
- o_done  out  1  one-cycle pulse when frame results update
- o_found  out  1  o_count >= MIN_COUNT
- o_count  out  20  qualifying dark pixels in last frame
- o_x_min  out  10  leftmost qualifying column
- o_x_max  out  10  rightmost qualifying column
- o_y_min  out  10  top qualifying row
- o_y_max  out  10  bottom qualifying row

Behaviour:
- Reset (async, active-low): state S_IDLE; every output 0; internal x, y, run, count and working bbox cleared.
- Reset mid-frame: the frame is abandoned and no o_done is issued.
- States:
  - S_IDLE: i_valid is ignored. i_start=1 → S_ACTIVE. On entry to S_ACTIVE: x=y=0, run=0, work count=0, work x_min/y_min=all-ones, work x_max/y_max=0.
  - S_ACTIVE: each cycle with i_valid=1 accepts exactly one pixel at (x,y). Cycles with i_valid=0 are stalls; all state holds. i_start is ignored.
    - Accept when x==IMG_W-1 and y==IMG_H-1 → S_DONE.
  - S_DONE: one cycle, then S_IDLE. Pulses o_done. Loads the output registers from the working registers. If work count==0, bbox outputs load 0.
- Run filter, per accepted pixel:
  - i_bw=0 → run=0.
  - i_bw=1 → run=min(run+1, RUN_MIN).
  - When run becomes RUN_MIN on this pixel, the run just qualified: count += RUN_MIN; x_min=min(x_min, x-RUN_MIN+1); x_max=max(x_max, x); y_min=min(y_min, y); y_max=max(y_max, y).
  - When run was already RUN_MIN and i_bw=1: count += 1; x_max=max(x_max, x); the y bounds update the same way.
  - Runs never span rows: run is forced to 0 after the pixel at x==IMG_W-1 is processed.
- Counters: x increments per accepted pixel and wraps to 0 at IMG_W-1, incrementing y. Pixel at the wrap position is fully processed before the wrap.
- Widths: x and y are 10 bits unsigned; count is 20 bits (480000 max, no overflow). Comparisons are unsigned.
- Latency: o_done and new outputs appear exactly 1 cycle after the last pixel is accepted. o_found is combinational from registered o_count.
- i_start in the same cycle as o_done: ignored (state is S_DONE); a new start must arrive in S_IDLE.
- Outputs hold previous-frame values throughout the next S_ACTIVE.

Decomposition:
- Package bbox_pkg: state enum (S_IDLE, S_ACTIVE, S_DONE), widths COORD_W=10 and COUNT_W=20, default geometry constants.
- Sub-module raster_counter: x/y counters with enable, wrap, and combinational last_in_row and last_in_frame flags, parameterised by IMG_W and IMG_H.
- Run filter, bbox accumulation and FSM stay in the top module.

Test Plan:
- All-white frame (i_bw=0 for 480000 beats) → o_done 1 cycle after last beat; o_count=0, o_found=0, all bbox outputs 0.
- 20x20 dark square at x=100..119, y=50..69 → o_count=400, x_min=100, x_max=119, y_min=50, y_max=69, o_found=1.
- Isolated dark pairs (runs of 2) scattered across frame, RUN_MIN=3 → o_count=0, o_found=0.
- Dark pixels at x=798,799 of row 10 and x=0,1 of row 11 → not qualified across the row boundary; o_count=0.
- Square test with i_valid deasserted for 10 cycles every 1000 beats → identical results; o_done delayed by the total stall cycles.
- Assert i_rst_n=0 at pixel 200000, release, then run the square frame → no o_done for the aborted frame; outputs 0 until the new frame completes with o_count=400.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared widths, default frame geometry and FSM state encoding for the
// black/white bounding-box detector.
package bbox_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COUNT_W = 20;
  localparam int unsigned RUN_W   = 4;

  localparam int unsigned DEF_IMG_W     = 800;
  localparam int unsigned DEF_IMG_H     = 600;
  localparam int unsigned DEF_RUN_MIN   = 3;
  localparam int unsigned DEF_MIN_COUNT = 64;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACTIVE = 2'd1;
  localparam state_t S_DONE   = 2'd2;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position tracker: advances on each accepted pixel and flags the
// last column of a row and the last pixel of the frame.
module raster_counter
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last_in_row,
  output logic               o_last_in_frame
);

  logic [COORD_W-1:0] x_q, y_q;

  assign o_x             = x_q;
  assign o_y             = y_q;
  assign o_last_in_row   = (x_q == COORD_W'(IMG_W - 1));
  assign o_last_in_frame = o_last_in_row && (y_q == COORD_W'(IMG_H - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (i_clr) begin
      x_q <= '0;
      y_q <= '0;
    end else if (i_en) begin
      if (o_last_in_row) begin
        x_q <= '0;
        y_q <= o_last_in_frame ? '0 : y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bw_bbox_detector.sv
// Per-frame bounding box and count of dark pixels belonging to horizontal runs
// of at least RUN_MIN pixels; results held until the next frame completes.
module bw_bbox_detector
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_W     = DEF_IMG_W,
  parameter int unsigned IMG_H     = DEF_IMG_H,
  parameter int unsigned RUN_MIN   = DEF_RUN_MIN,
  parameter int unsigned MIN_COUNT = DEF_MIN_COUNT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic               i_bw,
  input  logic [9:0]         i_color,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_found,
  output logic [COUNT_W-1:0] o_count,
  output logic [COORD_W-1:0] o_x_min,
  output logic [COORD_W-1:0] o_x_max,
  output logic [COORD_W-1:0] o_y_min,
  output logic [COORD_W-1:0] o_y_max
);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x, y, x_first;
  logic               last_in_row, last_in_frame;
  logic               start_frame, accept, hit, new_run;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic               unused_color;

  assign unused_color = ^i_color;
  assign start_frame  = (state_q == S_IDLE) && i_start;
  assign accept       = (state_q == S_ACTIVE) && i_valid;
  // A dark pixel counts once the run reaches RUN_MIN on it or was already there.
  assign hit          = accept && i_bw && (run_q >= RUN_W'(RUN_MIN - 1));
  assign new_run      = run_q != RUN_W'(RUN_MIN);
  assign x_first      = x - COORD_W'(RUN_MIN - 1);

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_clr          (start_frame),
    .i_en           (accept),
    .o_x            (x),
    .o_y            (y),
    .o_last_in_row  (last_in_row),
    .o_last_in_frame(last_in_frame)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (i_start) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && last_in_frame) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (start_frame) begin
      run_d  = '0;
      cnt_d  = '0;
      xmin_d = '1;
      ymin_d = '1;
      xmax_d = '0;
      ymax_d = '0;
    end else if (accept) begin
      if (!i_bw) run_d = '0;
      else if (new_run) run_d = run_q + RUN_W'(1);
      if (hit) begin
        if (new_run) begin
          cnt_d = cnt_q + COUNT_W'(RUN_MIN);
          if (x_first < xmin_q) xmin_d = x_first;
        end else begin
          cnt_d = cnt_q + COUNT_W'(1);
        end
        if (x > xmax_q) xmax_d = x;
        if (y < ymin_q) ymin_d = y;
        if (y > ymax_q) ymax_d = y;
      end
      if (last_in_row) run_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      cnt_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
    end
  end

  // Results are captured from next-state values so they are valid with o_done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
      o_x_min <= '0;
      o_x_max <= '0;
      o_y_min <= '0;
      o_y_max <= '0;
    end else if (accept && last_in_frame) begin
      o_count <= cnt_d;
      if (cnt_d == '0) begin
        o_x_min <= '0;
        o_x_max <= '0;
        o_y_min <= '0;
        o_y_max <= '0;
      end else begin
        o_x_min <= xmin_d;
        o_x_max <= xmax_d;
        o_y_min <= ymin_d;
        o_y_max <= ymax_d;
      end
    end
  end

  assign o_busy  = (state_q == S_ACTIVE);
  assign o_done  = (state_q == S_DONE);
  assign o_found = (o_count >= COUNT_W'(MIN_COUNT));

endmodule

// File: tb/tb_bw_bbox_detector.sv
// Self-checking bench for bw_bbox_detector on a reduced 64x48 frame: fixed
// pattern table, random frames against a run-scanning model, corner sequences.
module tb_bw_bbox_detector;
  import bbox_pkg::*;

  localparam int W    = 64;
  localparam int H    = 48;
  localparam int N    = W * H;
  localparam int RMIN = 3;
  localparam int MINC = 64;

  logic               i_clk   = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_bw    = 1'b0;
  logic [9:0]         i_color = '0;
  logic               o_busy, o_done, o_found;
  logic [COUNT_W-1:0] o_count;
  logic [COORD_W-1:0] o_x_min, o_x_max, o_y_min, o_y_max;

  bw_bbox_detector #(
    .IMG_W    (W),
    .IMG_H    (H),
    .RUN_MIN  (RMIN),
    .MIN_COUNT(MINC)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_valid(i_valid),
    .i_bw   (i_bw),
    .i_color(i_color),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_found(o_found),
    .o_count(o_count),
    .o_x_min(o_x_min),
    .o_x_max(o_x_max),
    .o_y_min(o_y_min),
    .o_y_max(o_y_max)
  );

  always #5 i_clk = ~i_clk;

  longint cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  bit fr [H][W];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;
    int stall;
    int cnt;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    bit found;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scan each row for maximal dark runs; runs of RMIN or more count in full.
  task automatic model(output int c, output int xmn, output int xmx,
                       output int ymn, output int ymx);
    c = 0; xmn = W; xmx = -1; ymn = H; ymx = -1;
    for (int yy = 0; yy < H; yy++) begin
      int i;
      i = 0;
      while (i < W) begin
        if (!fr[yy][i]) begin
          i++;
        end else begin
          int j;
          j = i;
          while (j < W && fr[yy][j]) j++;
          if (j - i >= RMIN) begin
            c += j - i;
            if (i < xmn) xmn = i;
            if (j - 1 > xmx) xmx = j - 1;
            if (yy < ymn) ymn = yy;
            if (yy > ymx) ymx = yy;
          end
          i = j;
        end
      end
    end
    if (c == 0) begin
      xmn = 0; xmx = 0; ymn = 0; ymx = 0;
    end
  endtask

  task automatic fill(input int kind, input int dens);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) fr[yy][xx] = 1'b0;
    case (kind)
      1: for (int yy = 20; yy < 40; yy++)
           for (int xx = 30; xx < 50; xx++) fr[yy][xx] = 1'b1;
      2: for (int yy = 0; yy < H; yy += 3)
           for (int xx = 0; xx < W; xx++) fr[yy][xx] = (xx % 5) < 2;
      3: begin
           fr[10][W-2] = 1'b1; fr[10][W-1] = 1'b1;
           fr[11][0]   = 1'b1; fr[11][1]   = 1'b1;
         end
      4: for (int xx = W - 3; xx < W; xx++) fr[7][xx] = 1'b1;
      5: begin
           for (int xx = 0; xx < 4; xx++) fr[0][xx] = 1'b1;
           for (int xx = 10; xx < 15; xx++) fr[H-1][xx] = 1'b1;
         end
      6: for (int xx = 0; xx < W; xx++) fr[3][xx] = 1'b1;
      7: for (int xx = 0; xx < W - 1; xx++) fr[3][xx] = 1'b1;
      8: for (int yy = 0; yy < H; yy++)
           for (int xx = 0; xx < W; xx++) fr[yy][xx] = ($urandom_range(0, 99) < dens);
      default: ;
    endcase
  endtask

  // Start a frame, stream fr[][] with optional 10-cycle stalls, check timing.
  // A non-negative abort_at asserts reset before that pixel and returns.
  task automatic run_frame(input int stall_every, input int abort_at);
    longint t0;
    int     sc;
    int     prev_cnt;
    bit     early;
    prev_cnt = o_count;
    sc = 0;
    early = 1'b0;
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1;
    t0 = cyc;
    i_start = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (p == abort_at) begin
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        return;
      end
      if (stall_every > 0 && p > 0 && (p % stall_every) == 0) begin
        i_valid = 1'b0;
        repeat (10) begin
          if (o_done) early = 1'b1;
          @(posedge i_clk); #1;
        end
        sc += 10;
      end
      i_valid = 1'b1;
      i_bw    = fr[p / W][p % W];
      i_color = 10'($urandom);
      if (p == N / 2) begin
        chk("held_count", o_count, prev_cnt);
        chk("busy_mid", o_busy, 1);
      end
      if (o_done) early = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_bw    = 1'b0;
    chk("early_done", early, 0);
    chk("done_pulse", o_done, 1);
    chk("busy_after", o_busy, 0);
    chk("latency", cyc - t0, N + sc);
  endtask

  task automatic check_model();
    int c, xmn, xmx, ymn, ymx;
    model(c, xmn, xmx, ymn, ymx);
    chk("m_count", o_count, c);
    chk("m_x_min", o_x_min, xmn);
    chk("m_x_max", o_x_max, xmx);
    chk("m_y_min", o_y_min, ymn);
    chk("m_y_max", o_y_max, ymx);
    chk("m_found", o_found, c >= MINC);
  endtask

  initial begin
    tbl[0] = '{0, 0,   0,      0,     0,     0,  0,     0};
    tbl[1] = '{1, 0,   400,    30,    49,    20, 39,    1};
    tbl[2] = '{2, 0,   0,      0,     0,     0,  0,     0};
    tbl[3] = '{3, 0,   0,      0,     0,     0,  0,     0};
    tbl[4] = '{4, 0,   3,      W - 3, W - 1, 7,  7,     0};
    tbl[5] = '{5, 0,   9,      0,     14,    0,  H - 1, 0};
    tbl[6] = '{6, 0,   64,     0,     W - 1, 3,  3,     1};
    tbl[7] = '{7, 0,   63,     0,     W - 2, 3,  3,     0};
    tbl[8] = '{1, 500, 400,    30,    49,    20, 39,    1};

    #12;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_count", o_count, 0);
    chk("rst_bbox", {o_x_min, o_x_max, o_y_min, o_y_max}, 0);
    i_rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      fill(tbl[k].kind, 0);
      run_frame(tbl[k].stall, -1);
      chk($sformatf("t%0d_count", k), o_count, tbl[k].cnt);
      chk($sformatf("t%0d_x_min", k), o_x_min, tbl[k].xmin);
      chk($sformatf("t%0d_x_max", k), o_x_max, tbl[k].xmax);
      chk($sformatf("t%0d_y_min", k), o_y_min, tbl[k].ymin);
      chk($sformatf("t%0d_y_max", k), o_y_max, tbl[k].ymax);
      chk($sformatf("t%0d_found", k), o_found, tbl[k].found);
      check_model();
    end

    // Start raised during the done cycle must not launch a frame.
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("start_in_done_busy", o_busy, 0);
    chk("done_one_cycle", o_done, 0);
    @(posedge i_clk); #1;
    chk("still_idle", o_busy, 0);

    for (int r = 0; r < 3; r++) begin
      fill(8, 20 + 25 * r);
      run_frame((r == 1) ? 333 : 0, -1);
      check_model();
    end

    // Mid-frame reset: abandoned frame never reports, outputs clear.
    fill(1, 0);
    run_frame(0, N / 2);
    #2;
    chk("abort_busy", o_busy, 0);
    chk("abort_count", o_count, 0);
    chk("abort_bbox", {o_x_min, o_x_max, o_y_min, o_y_max}, 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      i_valid = 1'b1;
      i_bw    = 1'b1;
      repeat (N + 20) begin
        @(posedge i_clk); #1;
        if (o_done || o_busy) seen = 1'b1;
      end
      i_valid = 1'b0;
      i_bw    = 1'b0;
      chk("idle_ignores_valid", seen, 0);
    end
    run_frame(0, -1);
    chk("post_rst_count", o_count, 400);
    chk("post_rst_found", o_found, 1);
    check_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
